// File: rtl/instr_issue_if.sv
// Request/issue bundle between the instruction producer and instr_issue.
// master drives requests and control; slave (instr_issue) drives ready, issued word and status.
interface instr_issue_if;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  in_op;
    logic [4:0]  in_rd;
    logic [4:0]  in_rs1;
    logic [4:0]  in_rs2;
    logic        halt;
    logic        flush;
    logic [31:0] instr_o;
    logic        we_o;
    logic        busy;
    logic        err;

    modport master (
        output in_valid, in_op, in_rd, in_rs1, in_rs2, halt, flush,
        input  in_ready, instr_o, we_o, busy, err
    );

    modport slave (
        input  in_valid, in_op, in_rd, in_rs1, in_rs2, halt, flush,
        output in_ready, instr_o, we_o, busy, err
    );
endinterface

// File: rtl/instr_issue.sv
// Instruction-issue front end: encodes {op,rd,rs1,rs2} into RV32 R-type words, buffers them, issues one per cycle.
// Defining INSTR_ISSUE_CNT_EN adds the issued_cnt output counting issued ADD/SUB words.
module instr_issue #(
    parameter int DEPTH = 4,
    parameter int PTR_W = 2
) (
    input  logic         clk,
    input  logic         rst,
    instr_issue_if.slave bus
`ifdef INSTR_ISSUE_CNT_EN
    ,
    output logic [15:0]  issued_cnt
`endif
);
    localparam logic [31:0] NOP_WORD = 32'h0000_0013;

    typedef enum logic [1:0] {OP_ADD = 2'b00, OP_SUB = 2'b01, OP_NOP = 2'b10, OP_ILL = 2'b11} op_e;
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_HOLD} state_e;
    typedef struct packed {
        logic        wr;
        logic [31:0] word;
    } entry_t;

    entry_t           mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [PTR_W:0]   count;
    state_e           state, state_next;
    logic [31:0]      instr_q;
    logic             we_q, err_q;
    logic             full, empty, push, push_w, pop, illegal;
    entry_t           enc;

    assign full    = (count == (PTR_W+1)'(DEPTH));
    assign empty   = (count == '0);
    assign push    = bus.in_valid & ~full;
    assign illegal = (op_e'(bus.in_op) == OP_ILL);
    // Illegal ops complete the handshake but never occupy a slot.
    assign push_w  = push & ~illegal & ~bus.flush;

    assign bus.in_ready = ~full;
    assign bus.instr_o  = instr_q;
    assign bus.we_o     = we_q;
    assign bus.err      = err_q;
    assign bus.busy     = ~empty | we_q;

    // NOTE: every variable written in always_comb gets a default first, so no path infers a latch.
    always_comb begin
        enc = '{wr: 1'b0, word: NOP_WORD};
        unique case (op_e'(bus.in_op))
            OP_ADD:  enc = '{wr: 1'b1, word: {7'b0000000, bus.in_rs2, bus.in_rs1, 3'b000, bus.in_rd, 7'b0110011}};
            OP_SUB:  enc = '{wr: 1'b1, word: {7'b0100000, bus.in_rs2, bus.in_rs1, 3'b000, bus.in_rd, 7'b0110011}};
            default: ;
        endcase
    end

    always_comb begin
        state_next = state;
        pop        = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (!empty) begin
                    if (bus.halt) begin
                        state_next = S_HOLD;
                    end else begin
                        pop        = 1'b1;
                        state_next = S_RUN;
                    end
                end
            end
            S_RUN: begin
                if (empty) begin
                    state_next = S_IDLE;
                end else if (bus.halt) begin
                    state_next = S_HOLD;
                end else begin
                    pop = 1'b1;
                    if (count == (PTR_W+1)'(1) && !push_w) state_next = S_IDLE;
                end
            end
            S_HOLD: begin
                // Leaving HOLD costs one edge before popping resumes.
                if (empty)          state_next = S_IDLE;
                else if (!bus.halt) state_next = S_RUN;
            end
            default: state_next = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            state   <= S_IDLE;
            instr_q <= NOP_WORD;
            we_q    <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            err_q <= push & illegal & ~bus.flush;
            if (bus.flush) begin
                wr_ptr  <= '0;
                rd_ptr  <= '0;
                count   <= '0;
                state   <= S_IDLE;
                instr_q <= NOP_WORD;
                we_q    <= 1'b0;
            end else begin
                state <= state_next;
                count <= count + (PTR_W+1)'(push_w) - (PTR_W+1)'(pop);
                if (push_w) wr_ptr <= wr_ptr + PTR_W'(1);
                if (pop) begin
                    rd_ptr  <= rd_ptr + PTR_W'(1);
                    instr_q <= mem[rd_ptr].word;
                    we_q    <= mem[rd_ptr].wr;
                end else begin
                    we_q <= 1'b0;
                end
            end
        end
    end

    // NOTE: storage is not reset; count and pointers alone decide which entries are valid.
    always_ff @(posedge clk) begin
        if (push_w) mem[wr_ptr] <= enc;
    end

`ifdef INSTR_ISSUE_CNT_EN
    always_ff @(posedge clk) begin
        if (rst)                                       issued_cnt <= '0;
        else if (!bus.flush && pop && mem[rd_ptr].wr)  issued_cnt <= issued_cnt + 16'd1;
    end
`endif
endmodule

// File: tb/tb_instr_issue.sv
// Self-checking bench for instr_issue: directed scenarios with literal expectations plus randomized traffic
// compared every cycle against a queue-based model of the issue rules.
module tb_instr_issue;
    localparam int DEPTH = 4;
    localparam logic [31:0] NOP_WORD = 32'h0000_0013;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    instr_issue_if bus ();
`ifdef INSTR_ISSUE_CNT_EN
    logic [15:0] issued_cnt;
`endif

    instr_issue #(.DEPTH(DEPTH), .PTR_W(2)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
`ifdef INSTR_ISSUE_CNT_EN
        ,
        .issued_cnt(issued_cnt)
`endif
    );

    int n_cmp  = 0;
    int n_fail = 0;
    bit chk_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %h, want %h", name, $time, act, exp);
        end
    endtask

    function automatic logic [31:0] encode(input logic [1:0] op, input logic [4:0] rd, rs1, rs2);
        logic [31:0] f7;
        f7 = (op == 2'd1) ? 32'h20 : 32'h0;
        if (op == 2'd2 || op == 2'd3) return NOP_WORD;
        return (f7 << 25) | (32'(rs2) << 20) | (32'(rs1) << 15) | (32'(rd) << 7) | 32'h33;
    endfunction

    // Reference model: a queue of {wr, word}; a paused flag captures that issue resumes one edge after halt drops.
    logic [32:0] mq[$];
    logic [32:0] m_head;
    bit          m_paused;
    logic [31:0] m_instr;
    bit          m_we, m_err;
    logic [15:0] m_cnt;
    bit          m_accept, m_pop, m_nonempty;

    always @(posedge clk) begin
        if (rst) begin
            mq.delete();
            m_paused = 1'b0;
            m_instr  = NOP_WORD;
            m_we     = 1'b0;
            m_err    = 1'b0;
            m_cnt    = 16'd0;
        end else begin
            m_accept   = bus.in_valid && (mq.size() < DEPTH) && !bus.flush;
            m_nonempty = (mq.size() != 0);
            m_pop      = !bus.flush && !m_paused && !bus.halt && m_nonempty;
            m_err      = m_accept && (bus.in_op == 2'd3);
            if (bus.flush) begin
                mq.delete();
                m_paused = 1'b0;
                m_instr  = NOP_WORD;
                m_we     = 1'b0;
            end else begin
                m_paused = m_nonempty && bus.halt;
                if (m_pop) begin
                    m_head  = mq.pop_front();
                    m_instr = m_head[31:0];
                    m_we    = m_head[32];
                    if (m_head[32]) m_cnt = m_cnt + 16'd1;
                end else begin
                    m_we = 1'b0;
                end
                if (m_accept && bus.in_op != 2'd3)
                    mq.push_back({bus.in_op[1] == 1'b0, encode(bus.in_op, bus.in_rd, bus.in_rs1, bus.in_rs2)});
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("instr_o", bus.instr_o, m_instr);
            check("we_o", 32'(bus.we_o), 32'(m_we));
            check("busy", 32'(bus.busy), 32'((mq.size() != 0) || m_we));
            check("in_ready", 32'(bus.in_ready), 32'(mq.size() < DEPTH));
            check("err", 32'(bus.err), 32'(m_err));
`ifdef INSTR_ISSUE_CNT_EN
            check("issued_cnt", 32'(issued_cnt), 32'(m_cnt));
`endif
        end
    end

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic req(input logic [1:0] op, input logic [4:0] rd, rs1, rs2);
        bus.in_valid = 1'b1;
        bus.in_op    = op;
        bus.in_rd    = rd;
        bus.in_rs1   = rs1;
        bus.in_rs2   = rs2;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_instr"}, bus.instr_o, NOP_WORD);
        check({tag, "_we"}, 32'(bus.we_o), 32'd0);
        check({tag, "_ready"}, 32'(bus.in_ready), 32'd1);
        check({tag, "_busy"}, 32'(bus.busy), 32'd0);
        check({tag, "_err"}, 32'(bus.err), 32'd0);
    endtask

`ifdef INSTR_ISSUE_CNT_EN
    logic [15:0] cnt_base;
`endif

    initial begin
        bus.in_valid = 1'b0;
        bus.in_op    = 2'd0;
        bus.in_rd    = 5'd0;
        bus.in_rs1   = 5'd0;
        bus.in_rs2   = 5'd0;
        bus.halt     = 1'b0;
        bus.flush    = 1'b0;
        rst          = 1'b1;
        repeat (2) cycle();
        rst    = 1'b0;
        chk_en = 1'b1;
        check_reset_outputs("reset");
`ifdef INSTR_ISSUE_CNT_EN
        check("reset_cnt", 32'(issued_cnt), 32'd0);
`endif

        // Single ADD: visible one edge after the push, we_o for exactly one cycle.
        req(2'd0, 5'd3, 5'd1, 5'd2);
        cycle();
        bus.in_valid = 1'b0;
        check("add_busy", 32'(bus.busy), 32'd1);
        cycle();
        check("add_word", bus.instr_o, 32'h002081B3);
        check("add_we", 32'(bus.we_o), 32'd1);
        cycle();
        check("add_we_drop", 32'(bus.we_o), 32'd0);
        check("add_hold_word", bus.instr_o, 32'h002081B3);

        // SUB then NOP back-to-back.
        req(2'd1, 5'd5, 5'd3, 5'd4);
        cycle();
        req(2'd2, 5'd7, 5'd7, 5'd7);
        cycle();
        bus.in_valid = 1'b0;
        check("sub_word", bus.instr_o, 32'h404182B3);
        check("sub_we", 32'(bus.we_o), 32'd1);
        cycle();
        check("nop_word", bus.instr_o, NOP_WORD);
        check("nop_we", 32'(bus.we_o), 32'd0);
        cycle();

        // Fill under halt, stall a fifth request, then drain four words on consecutive cycles.
        bus.halt = 1'b1;
        for (int i = 0; i < 4; i++) begin
            req(2'd0, 5'(i + 1), 5'(i + 10), 5'(i + 20));
            cycle();
        end
        check("full_ready", 32'(bus.in_ready), 32'd0);
        check("halt_we", 32'(bus.we_o), 32'd0);
        req(2'd1, 5'd31, 5'd31, 5'd31);
        repeat (2) cycle();
        check("stall_ready", 32'(bus.in_ready), 32'd0);
        bus.in_valid = 1'b0;
        bus.halt     = 1'b0;
        cycle();
        for (int i = 0; i < 4; i++) begin
            cycle();
            check("drain_we", 32'(bus.we_o), 32'd1);
            check("drain_word", bus.instr_o, encode(2'd0, 5'(i + 1), 5'(i + 10), 5'(i + 20)));
        end
        cycle();
        check("drain_done_we", 32'(bus.we_o), 32'd0);
        check("drain_done_busy", 32'(bus.busy), 32'd0);

        // Illegal op: err pulse, nothing buffered.
        req(2'd3, 5'd9, 5'd9, 5'd9);
        cycle();
        bus.in_valid = 1'b0;
        check("ill_err", 32'(bus.err), 32'd1);
        check("ill_busy", 32'(bus.busy), 32'd0);
        cycle();
        check("ill_err_drop", 32'(bus.err), 32'd0);
        check("ill_we", 32'(bus.we_o), 32'd0);

        // Flush with three entries and a same-edge push.
        bus.halt = 1'b1;
        for (int i = 0; i < 3; i++) begin
            req(2'd1, 5'(i), 5'(i + 1), 5'(i + 2));
            cycle();
        end
        req(2'd0, 5'd1, 5'd1, 5'd1);
        bus.flush = 1'b1;
        cycle();
        bus.flush    = 1'b0;
        bus.in_valid = 1'b0;
        bus.halt     = 1'b0;
        check("flush_we", 32'(bus.we_o), 32'd0);
        check("flush_instr", bus.instr_o, NOP_WORD);
        check("flush_ready", 32'(bus.in_ready), 32'd1);
        check("flush_busy", 32'(bus.busy), 32'd0);
        repeat (2) cycle();
        check("flush_nothing_left", 32'(bus.busy), 32'd0);

`ifdef INSTR_ISSUE_CNT_EN
        cnt_base = issued_cnt;
        for (int i = 0; i < 7; i++) begin
            req((i == 2 || i == 5) ? 2'd2 : 2'(i % 2), 5'(i), 5'(i), 5'(i));
            cycle();
        end
        bus.in_valid = 1'b0;
        repeat (3) cycle();
        check("cnt_delta", 32'(issued_cnt - cnt_base), 32'd5);
`endif

        // Reset mid-stream drops everything.
        for (int i = 0; i < 3; i++) begin
            req(2'd0, 5'(i + 4), 5'd2, 5'd3);
            cycle();
        end
        bus.in_valid = 1'b0;
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        check_reset_outputs("midrst");
`ifdef INSTR_ISSUE_CNT_EN
        check("midrst_cnt", 32'(issued_cnt), 32'd0);
`endif

        // Randomized traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            bus.in_valid = ($urandom_range(0, 9) < 7);
            bus.in_op    = 2'($urandom_range(0, 3));
            bus.in_rd    = 5'($urandom);
            bus.in_rs1   = 5'($urandom);
            bus.in_rs2   = 5'($urandom);
            bus.halt     = ($urandom_range(0, 9) < 2);
            bus.flush    = ($urandom_range(0, 99) < 3);
            rst          = ($urandom_range(0, 299) == 0);
            cycle();
        end
        bus.in_valid = 1'b0;
        bus.halt     = 1'b0;
        bus.flush    = 1'b0;
        rst          = 1'b0;
        repeat (8) cycle();
        check("final_idle_busy", 32'(bus.busy), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
